// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity modes and default bit period for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int CLK_DIV_DEFAULT = 434;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_bps_gen.sv
// uart_rx_bps_gen: bit-period counter producing a mid-bit sample strobe.
// Held at zero by clr; the strobe repeats every CLK_DIV cycles while enabled.
module uart_rx_bps_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic sample
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] MID  = CW'(CLK_DIV / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample = en && !clr && (cnt_q == MID);

endmodule

// File: rtl/uart_rx_param_module.sv
// uart_rx_param_module: parameterised UART receiver with a held, handshaked output word.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_param_module
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = PAR_NONE
) (
    input  logic                 CLOCK,
    input  logic                 RST_n,
    input  logic                 RX_En_Sig,
    input  logic                 RXD,
    input  logic                 RX_Ready,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Valid,
    output logic                 RX_Parity_Err,
    output logic                 RX_Frame_Err,
    output logic                 RX_Overrun,
    output logic                 RX_Busy
);

`ifdef UART_RX_PARITY_EN
    localparam int PAR_MODE = PARITY;
`endif

    logic [1:0]           sync_q;
    logic                 prev_q;
    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 oferr_q, oferr_d;
    logic                 ovr_q, ovr_d;
    logic                 done;
    logic                 sample;
    logic                 bps_clr;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 operr_q, operr_d;
`endif

    assign rx_s    = sync_q[1];
    assign bps_clr = (state_q == S_IDLE);

    uart_rx_bps_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bps (
        .clk    (CLOCK),
        .rst_n  (RST_n),
        .clr    (bps_clr),
        .en     (!bps_clr),
        .sample (sample)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (RX_En_Sig && prev_q && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample) begin
                    perr_d  = (^shift_q) ^ rx_s ^ (PAR_MODE == PAR_ODD);
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample) begin
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disabling the receiver abandons any frame in flight.
        if (!RX_En_Sig) begin
            state_d = S_IDLE;
            done    = 1'b0;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        oferr_d = oferr_q;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        operr_d = operr_q;
`endif
        if (done) begin
            if (valid_q && !RX_Ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
                oferr_d = ferr_d;
`ifdef UART_RX_PARITY_EN
                operr_d = perr_q;
`endif
            end
        end else if (valid_q && RX_Ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= S_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            oferr_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            operr_q <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], RXD};
            prev_q  <= rx_s;
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            oferr_q <= oferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            operr_q <= operr_d;
`endif
        end
    end

    assign RX_Data      = data_q;
    assign RX_Valid     = valid_q;
    assign RX_Frame_Err = oferr_q;
    assign RX_Overrun   = ovr_q;
    assign RX_Busy      = (state_q != S_IDLE);

`ifdef UART_RX_PARITY_EN
    assign RX_Parity_Err = operr_q;
`else
    // Parity hardware is compiled out, so the PARITY setting has no effect.
    localparam logic PAR_ON = 1'b0 & (PARITY != PAR_NONE);
    assign RX_Parity_Err = PAR_ON;
`endif

endmodule

// File: tb/tb_uart_rx_param_module.sv
// tb_uart_rx_param_module: scoreboard bench for two receiver builds (8N1 and 8x2 with parity).
// Frames are issued by a serial driver; a monitor checks every accepted word.
module tb_uart_rx_param_module;

    localparam int CD = 16;
    localparam int NB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB_EFF = 1;
`else
    localparam int PB_EFF = 0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    en, rxd, rdy;
    logic [NB-1:0] dout [2];
    logic [1:0]    valid, perr, ferr, ovr, busy;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ovr_seen [2] = '{0, 0};
    int   ovr_exp  [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_rx_param_module #(
        .CLK_DIV(CD), .DATA_BITS(NB), .STOP_BITS(1), .PARITY(0)
    ) u_a (
        .CLOCK(clk), .RST_n(rst_n), .RX_En_Sig(en[0]), .RXD(rxd[0]),
        .RX_Ready(rdy[0]), .RX_Data(dout[0]), .RX_Valid(valid[0]),
        .RX_Parity_Err(perr[0]), .RX_Frame_Err(ferr[0]),
        .RX_Overrun(ovr[0]), .RX_Busy(busy[0])
    );

    uart_rx_param_module #(
        .CLK_DIV(CD), .DATA_BITS(NB), .STOP_BITS(2), .PARITY(1)
    ) u_b (
        .CLOCK(clk), .RST_n(rst_n), .RX_En_Sig(en[1]), .RXD(rxd[1]),
        .RX_Ready(rdy[1]), .RX_Data(dout[1]), .RX_Valid(valid[1]),
        .RX_Parity_Err(perr[1]), .RX_Frame_Err(ferr[1]),
        .RX_Overrun(ovr[1]), .RX_Busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: word as sent; even parity error if total ones odd; frame error if any stop low.
    function automatic exp_t model(input int k, input logic [7:0] d,
                                   input logic pb, input logic [1:0] st);
        exp_t e;
        int   ones;
        ones = $countones(d) + int'(pb);
        e.d  = d;
        e.pe = (k == 1 && PB_EFF == 1) ? (ones % 2 == 1) : 1'b0;
        e.fe = (k == 0) ? !st[0] : !(st[0] && st[1]);
        return e;
    endfunction

    task automatic push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic tx_bit(input int k, input logic b);
        rxd[k] = b;
        repeat (CD) @(negedge clk);
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic pb,
                        input logic [1:0] st, input bit deliver);
        if (deliver) push(k, model(k, d, pb, st));
        tx_bit(k, 1'b0);
        for (int i = 0; i < NB; i++) tx_bit(k, d[i]);
        if (k == 1 && PB_EFF == 1) tx_bit(k, pb);
        tx_bit(k, st[0]);
        if (k == 1) tx_bit(k, st[1]);
        rxd[k] = 1'b1;
        // a low stop bit needs idle time so the next start edge is visible
        if (!st[0] || (k == 1 && !st[1])) repeat (CD) @(negedge clk);
    endtask

    task automatic take(input int k);
        exp_t e;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word_dut%0d: got %02h, required no word",
                     k, dout[k]);
        end else begin
            if (k == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("data_dut%0d", k), 32'(dout[k]), 32'(e.d));
            chk($sformatf("parity_err_dut%0d", k), 32'(perr[k]), 32'(e.pe));
            chk($sformatf("frame_err_dut%0d", k), 32'(ferr[k]), 32'(e.fe));
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (ovr[k]) ovr_seen[k]++;
                if (valid[k] && rdy[k]) take(k);
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 40 * CD) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: pending %0d/%0d, required 0/0",
                     q0.size(), q1.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_data%0d", tag, k), 32'(dout[k]), 0);
            chk($sformatf("%s_valid%0d", tag, k), 32'(valid[k]), 0);
            chk($sformatf("%s_perr%0d", tag, k), 32'(perr[k]), 0);
            chk($sformatf("%s_ferr%0d", tag, k), 32'(ferr[k]), 0);
            chk($sformatf("%s_ovr%0d", tag, k), 32'(ovr[k]), 0);
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        logic [7:0] d;
        logic [1:0] st;
        logic       pb;

        rst_n = 1'b0;
        en    = 2'b11;
        rxd   = 2'b11;
        rdy   = 2'b11;
        repeat (3) @(negedge clk);
        #1 chk_reset("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send(0, 8'hA5, 1'b0, 2'b11, 1);
        send(1, 8'h37, 1'b0, 2'b11, 1);
        send(1, 8'h37, 1'b1, 2'b11, 1);
        send(0, 8'h55, 1'b0, 2'b10, 1);
        send(1, 8'h55, 1'b0, 2'b01, 1);
        drain();

        rxd[0] = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("glitch_busy_high", 32'(busy[0]), 1);
        rxd[0] = 1'b1;
        repeat (11) @(negedge clk);
        #1 chk("glitch_busy_low", 32'(busy[0]), 0);
        chk("glitch_valid", 32'(valid[0]), 0);

        rdy[0] = 1'b0;
        send(0, 8'h11, 1'b0, 2'b11, 1);
        send(0, 8'h22, 1'b0, 2'b11, 0);
        ovr_exp[0]++;
        repeat (4) @(negedge clk);
        #1 chk("held_data", 32'(dout[0]), 32'h11);
        chk("held_valid", 32'(valid[0]), 1);
        chk("overrun_count", 32'(ovr_seen[0]), 32'(ovr_exp[0]));
        @(negedge clk);
        rdy[0] = 1'b1;
        drain();

        rdy[0] = 1'b0;
        send(0, 8'h11, 1'b0, 2'b11, 1);
        fork
            send(0, 8'h22, 1'b0, 2'b11, 1);
            begin
                repeat (9 * CD + 10) @(negedge clk);
                rdy[0] = 1'b1;
            end
        join
        drain();
        chk("overrun_count_accept", 32'(ovr_seen[0]), 32'(ovr_exp[0]));

        rdy[0] = 1'b0;
        send(0, 8'h33, 1'b0, 2'b11, 1);
        fork
            send(0, 8'h5A, 1'b0, 2'b11, 0);
            begin
                repeat (4 * CD) @(negedge clk);
                chk("abort_busy_before", 32'(busy[0]), 1);
                en[0] = 1'b0;
                repeat (2) @(negedge clk);
                #1 chk("abort_busy_after", 32'(busy[0]), 0);
            end
        join
        repeat (2) @(negedge clk);
        en[0] = 1'b1;
        #1 chk("abort_held_data", 32'(dout[0]), 32'h33);
        chk("abort_held_valid", 32'(valid[0]), 1);
        @(negedge clk);
        rdy[0] = 1'b1;
        drain();

        tx_bit(0, 1'b0);
        tx_bit(0, 1'b1);
        tx_bit(0, 1'b1);
        tx_bit(0, 1'b0);
        rxd[0] = 1'b1;
        repeat (CD / 2) @(negedge clk);
        chk("midreset_busy_before", 32'(busy[0]), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_reset("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CD) @(negedge clk);
        send(0, 8'h0F, 1'b0, 2'b11, 1);
        drain();

        for (int n = 0; n < 40; n++) begin
            k  = int'($urandom_range(0, 1));
            d  = 8'($urandom);
            pb = 1'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            if (k == 0) st[1] = 1'b1;
            send(k, d, pb, st, 1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        drain();

        repeat (2 * CD) @(negedge clk);
        chk("overrun_total_dut0", 32'(ovr_seen[0]), 32'(ovr_exp[0]));
        chk("overrun_total_dut1", 32'(ovr_seen[1]), 32'(ovr_exp[1]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param_module.md
UART_RX_PARAM_MODULE -- requirements
Module: uart_rx_param_module

Interface
REQ-001 Parameter CLK_DIV, default 434, CLOCK cycles per bit (50 MHz / 115200), legal range 4..65535, SHALL be honoured.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame, legal range 5..9, SHALL be honoured.
REQ-003 Parameter STOP_BITS, default 1, stop bits checked, legal values 1 or 2, SHALL be honoured.
REQ-004 Parameter PARITY, default 0, parity mode (0 none, 1 even, 2 odd), SHALL be honoured.
REQ-005 CLOCK  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-006 RST_n  in  1  asynchronous, active-low reset.
REQ-007 RX_En_Sig  in  1  receiver enable; low SHALL hold or force IDLE.
REQ-008 RXD  in  1  asynchronous serial line, idle high.
REQ-009 RX_Ready  in  1  consumer accepts the held word.
REQ-010 RX_Data  out  DATA_BITS  received word, LSB = first data bit.
REQ-011 RX_Valid  out  1  RX_Data and error flags valid.
REQ-012 RX_Parity_Err  out  1  parity mismatch for the held word.
REQ-013 RX_Frame_Err  out  1  any sampled stop bit low for the held word.
REQ-014 RX_Overrun  out  1  one-cycle pulse when a completed frame is dropped.
REQ-015 RX_Busy  out  1  high in every state except IDLE.

Function
REQ-016 RXD SHALL pass a 2-FF synchroniser (reset value 1); all sampling SHALL use the synchronised signal.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START SHALL occur on a synchronised high-to-low edge while RX_En_Sig=1; the bit counter SHALL then clear.
REQ-019 The bit counter SHALL count 0..CLK_DIV-1; the start bit SHALL be sampled at count CLK_DIV/2-1; each later bit SHALL be sampled exactly CLK_DIV cycles after the previous sample.
REQ-020 A start sample of 1 SHALL be a false start: return to IDLE, no RX_Valid, no flags.
REQ-021 DATA SHALL capture DATA_BITS samples LSB first, then go to PARITY if PARITY!=0, else STOP.
REQ-022 PARITY SHALL set the parity-error result when the XOR of data bits and parity bit is 1 (even) or 0 (odd).
REQ-023 STOP SHALL sample STOP_BITS bits; any 0 SHALL set the frame-error result; after the last stop sample the FSM SHALL return to IDLE the next cycle, so a start edge within the remaining half bit is detected.
REQ-024 On the cycle after the last stop sample, the word and both error results SHALL be loaded into the output registers and RX_Valid SHALL be 1; frames with errors SHALL still be delivered.
REQ-025 RX_Valid SHALL stay high, with RX_Data and flags stable, until a cycle with RX_Ready=1, then clear the next cycle.
REQ-026 A frame completing while RX_Valid=1 and RX_Ready=0 SHALL be dropped, the held word kept, and RX_Overrun pulsed for one cycle.
REQ-027 A frame completing in the same cycle as an accept (RX_Valid=1, RX_Ready=1) SHALL load the new word, keep RX_Valid=1 and not pulse RX_Overrun.
REQ-028 RX_En_Sig=0 mid-frame SHALL abort to IDLE on the next edge with no RX_Valid; an already-held word SHALL remain valid.

Reset
REQ-029 While RST_n=0: state IDLE, counters 0, synchroniser 1, RX_Data 0, RX_Valid 0, RX_Parity_Err 0, RX_Frame_Err 0, RX_Overrun 0, RX_Busy 0; reset mid-frame SHALL discard the frame.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: the PARITY state and checking SHALL be compiled in per REQ-022.
REQ-031 Macro UART_RX_PARITY_EN undefined: the PARITY state and logic SHALL be absent; PARITY SHALL be treated as 0; RX_Parity_Err SHALL be tied 0.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state encoding, parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the default CLK_DIV.
REQ-033 The bit-timing counter SHALL be sub-module uart_rx_bps_gen (clear, enable, CLK_DIV; outputs a mid-bit sample pulse).

Verification (CLK_DIV=16)
REQ-034 8N1, send 0xA5 -> RX_Valid=1, RX_Data=0xA5, both error flags 0, 1 cycle after the stop sample.
REQ-035 PARITY=1, send 0x37 with parity bit 0 -> RX_Data=0x37, RX_Parity_Err=1; with parity bit 1 -> RX_Parity_Err=0.
REQ-036 Send 0x55 with stop bit 0 -> RX_Data=0x55, RX_Frame_Err=1; STOP_BITS=2 with second stop bit 0 -> RX_Frame_Err=1.
REQ-037 Low glitch of 5 cycles on RXD -> no RX_Valid, RX_Busy returns to 0 by cycle 10.
REQ-038 Send 0x11 then 0x22 back-to-back with RX_Ready=0 -> RX_Data=0x11, one RX_Overrun pulse; with RX_Ready=1 at the second completion -> RX_Data=0x22, no pulse.
REQ-039 Assert RST_n=0 during data bit 3, then send 0x0F -> only 0x0F delivered, all outputs 0 during reset.
